// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle RV32 datapath sharing one
// instruction/data memory port. Handles R-type, lw, sw and beq, and retires
// one instruction per pass through the state sequence.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a wait counter watches the memory handshake in FETCH/MEM.
//   After TIMEOUT_CYCLES consecutive stalled cycles, the next stalled cycle
//   sends the FSM to ERR. When undefined, the FSM waits indefinitely.
//
// Outputs decode the current state. ir_we_o, pc_we_o (sw retire) and
// pc_src_o (beq) also depend on the inputs, so the asynchronous reset
// drops every strobe immediately.

module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        run_i,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_src_o,
    output logic        alu_src_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        reg_we_o,
    output logic        mem_to_reg_o,
    output logic        instr_done_o,
    output logic        err_o,
    output logic [3:0]  state_o
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB_R   = 4'd6;
    localparam logic [3:0] S_WB_L   = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ERR    = 4'd9;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    // R-type ALU operation from funct7/funct3. Only funct7 == 0 decodes
    // funct3. Every other funct7 value selects subtract.
    function automatic logic [3:0] r_alu_ctrl(input logic [6:0] funct7,
                                              input logic [2:0] funct3);
        logic [3:0] op;
        if (funct7 == 7'h00) begin
            case (funct3)
                3'b000:  op = ALU_ADD;
                3'b111:  op = ALU_AND;
                default: op = ALU_OR;
            endcase
        end else begin
            op = ALU_SUB;
        end
        return op;
    endfunction

    logic [3:0] state_r;
    logic [3:0] state_next_s;
    logic [3:0] retire_next_s;
    logic [6:0] opcode_s;
    logic [3:0] r_alu_s;
    logic       is_sw_s;
    logic       timeout_s;
    logic       unused_s;

    assign opcode_s      = instr_i[6:0];
    assign r_alu_s       = r_alu_ctrl(instr_i[31:25], instr_i[14:12]);
    assign is_sw_s       = (opcode_s == OP_SW);
    assign retire_next_s = run_i ? S_FETCH : S_IDLE;
    assign state_o       = state_r;
    assign instr_done_o  = pc_we_o;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_cnt_r;
    logic       waiting_s;

    assign waiting_s = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready_i;
    assign timeout_s = waiting_s && (wait_cnt_r == TIMEOUT_LIMIT);

    // Count consecutive stalled handshake cycles. The count clears on any
    // cycle that is not a stalled FETCH/MEM cycle, which covers state entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt_r <= 8'd0;
        end else if (waiting_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    assign unused_s = ^{instr_i[24:15], instr_i[11:7]};
`else
    assign timeout_s = 1'b0;
    assign unused_s  = ^{instr_i[24:15], instr_i[11:7], (TIMEOUT_CYCLES != 0)};
`endif

    // State register. Only the asynchronous reset leaves ERR.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection. Retire states return to FETCH or IDLE based on run_i.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (run_i) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (timeout_s) begin
                    state_next_s = S_ERR;
                end else if (mem_ready_i) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_R:         state_next_s = S_EXEC_R;
                    OP_LW, OP_SW: state_next_s = S_ADDR;
                    OP_BEQ:       state_next_s = S_BRANCH;
                    default:      state_next_s = S_ERR;
                endcase
            end
            S_EXEC_R: state_next_s = S_WB_R;
            S_ADDR:   state_next_s = S_MEM;
            S_MEM: begin
                if (timeout_s) begin
                    state_next_s = S_ERR;
                end else if (mem_ready_i) begin
                    if (is_sw_s) begin
                        state_next_s = retire_next_s;
                    end else begin
                        state_next_s = S_WB_L;
                    end
                end else begin
                    state_next_s = S_MEM;
                end
            end
            S_WB_R, S_WB_L, S_BRANCH: state_next_s = retire_next_s;
            S_ERR:    state_next_s = S_ERR;
            default:  state_next_s = S_ERR;
        endcase
    end

    // Datapath and memory strobes for the current state. ir_we_o and the
    // sw retire follow mem_ready_i in the same cycle.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_src_o       = 1'b0;
        alu_src_o      = 1'b0;
        alu_ctrl_o     = ALU_ADD;
        reg_we_o       = 1'b0;
        mem_to_reg_o   = 1'b0;
        err_o          = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                end else begin
                    ir_we_o = 1'b0;
                end
            end
            S_EXEC_R: begin
                alu_ctrl_o = r_alu_s;
            end
            S_WB_R: begin
                alu_ctrl_o = r_alu_s;
                reg_we_o   = 1'b1;
                pc_we_o    = 1'b1;
            end
            S_ADDR: begin
                alu_src_o = 1'b1;
            end
            S_MEM: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                alu_src_o      = 1'b1;
                mem_we_o       = is_sw_s;
                if (mem_ready_i && is_sw_s) begin
                    pc_we_o = 1'b1;
                end else begin
                    pc_we_o = 1'b0;
                end
            end
            S_WB_L: begin
                reg_we_o     = 1'b1;
                mem_to_reg_o = 1'b1;
                pc_we_o      = 1'b1;
            end
            S_BRANCH: begin
                alu_ctrl_o = ALU_SUB;
                pc_we_o    = 1'b1;
                pc_src_o   = zero_i;
            end
            S_ERR: begin
                err_o = 1'b1;
            end
            default: begin
                err_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. A random program with random memory wait
// states runs against a memory/IR model. Expected retire records are queued
// when the program is generated, and a monitor pops and compares them on each
// instr_done_o. Directed sections cover reset, illegal opcodes and the
// memory timeout.

module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        run_i;
    logic [31:0] instr_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_src_o;
    logic        alu_src_o, reg_we_o, mem_to_reg_o, instr_done_o, err_o;
    logic [3:0]  alu_ctrl_o;
    logic [3:0]  state_o;

    multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .instr_i(instr_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o), .ir_we_o(ir_we_o),
        .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .alu_src_o(alu_src_o),
        .alu_ctrl_o(alu_ctrl_o), .reg_we_o(reg_we_o), .mem_to_reg_o(mem_to_reg_o),
        .instr_done_o(instr_done_o), .err_o(err_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int N = 60;

    typedef struct {
        int         lat;
        logic       pc_src;
        logic       mem_we;
        logic       m2r;
        logic [3:0] alu;
        int         reg_writes;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] prog[N];
    int          fw[N];
    int          mw[N];
    logic        zb[N];

    int n_checks = 0;
    int n_fail   = 0;
    int retired  = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] strobes();
        return {mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_src_o,
                alu_src_o, reg_we_o, mem_to_reg_o, instr_done_o, err_o};
    endfunction

    // Reference rule for the R-type ALU select
    function automatic logic [3:0] ref_r_alu(input logic [6:0] f7, input logic [2:0] f3);
        if (f7 != 7'h00) return 4'b0110;
        if (f3 == 3'b000) return 4'b0010;
        if (f3 == 3'b111) return 4'b0000;
        return 4'b0001;
    endfunction

    // Build a random program and queue the expected retire record of each instruction
    task automatic gen_program();
        logic [31:0] r;
        int kind;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            r     = $urandom;
            kind  = $urandom_range(0, 3);
            fw[i] = $urandom_range(0, 3);
            mw[i] = $urandom_range(0, 3);
            zb[i] = 1'($urandom_range(0, 1));
            e.pc_src = 1'b0; e.mem_we = 1'b0; e.m2r = 1'b0; e.alu = 4'b0010;
            e.reg_writes = 0;
            case (kind)
                0: begin
                    case ($urandom_range(0, 2))
                        0:       r[31:25] = 7'h00;
                        1:       r[31:25] = 7'h20;
                        default: r[31:25] = 7'($urandom);
                    endcase
                    prog[i] = {r[31:7], 7'h33};
                    e.lat = 4 + fw[i];
                    e.alu = ref_r_alu(r[31:25], r[14:12]);
                    e.reg_writes = 1;
                end
                1: begin
                    prog[i] = {r[31:7], 7'h03};
                    e.lat = 5 + fw[i] + mw[i];
                    e.m2r = 1'b1;
                    e.reg_writes = 1;
                end
                2: begin
                    prog[i] = {r[31:7], 7'h23};
                    e.lat = 4 + fw[i] + mw[i];
                    e.mem_we = 1'b1;
                end
                default: begin
                    prog[i] = {r[31:7], 7'h63};
                    e.lat = 3 + fw[i];
                    e.pc_src = zb[i];
                    e.alu = 4'b0110;
                end
            endcase
            sb_q.push_back(e);
        end
    endtask

    // Monitor: measures cycles from FETCH entry and compares each retirement
    initial begin : monitor
        logic [3:0] prev_state;
        logic       prev_done;
        logic       prev_run;
        int         cyc;
        int         regc;
        exp_t       e;
        prev_state = 4'd0; prev_done = 1'b0; prev_run = 1'b0; cyc = 0; regc = 0;
        forever begin
            @(negedge clk_i);
            #2;
            if (mon_en) begin
                if (state_o == 4'd1 && prev_state != 4'd1) begin
                    cyc = 1;
                    regc = 0;
                end else begin
                    cyc++;
                end
                if (reg_we_o) regc++;
                if (prev_done) check("state_after_retire", 32'(state_o), prev_run ? 32'd1 : 32'd0);
                check("pc_we_eq_done", 32'(pc_we_o), 32'(instr_done_o));
                if (instr_done_o) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("latency", 32'(cyc), 32'(e.lat));
                        check("pc_src", 32'(pc_src_o), 32'(e.pc_src));
                        check("mem_we_at_retire", 32'(mem_we_o), 32'(e.mem_we));
                        check("mem_to_reg", 32'(mem_to_reg_o), 32'(e.m2r));
                        check("alu_ctrl_at_retire", 32'(alu_ctrl_o), 32'(e.alu));
                        check("reg_we_count", 32'(regc), 32'(e.reg_writes));
                    end
                    retired++;
                end
                prev_done = instr_done_o;
                prev_run  = run_i;
            end else begin
                prev_done = 1'b0;
            end
            prev_state = state_o;
        end
    end

    int  idx, cur, waited, req_cycles;
    bit  load, done_loop;

    initial begin
        rst_n_i = 1'b0; run_i = 1'b0; instr_i = 32'd0; zero_i = 1'b0; mem_ready_i = 1'b0;

        // Reset state
        #12;
        check("reset_strobes", 32'(strobes()), 32'd0);
        check("reset_alu", 32'(alu_ctrl_o), 32'h2);
        check("reset_state", 32'(state_o), 32'd0);

        // Reset asserted mid-FETCH together with mem_ready_i
        @(negedge clk_i); rst_n_i = 1'b1; run_i = 1'b1;
        @(posedge clk_i); #1;
        check("fetch_state", 32'(state_o), 32'd1);
        check("fetch_req", 32'(mem_req_o), 32'd1);
        @(negedge clk_i); rst_n_i = 1'b0; mem_ready_i = 1'b1;
        #1;
        check("async_rst_strobes", 32'(strobes()), 32'd0);
        check("async_rst_state", 32'(state_o), 32'd0);
        @(posedge clk_i); #1;
        check("rst_held_state", 32'(state_o), 32'd0);
        @(negedge clk_i); rst_n_i = 1'b1; mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        check("post_rst_fetch", 32'(state_o), 32'd1);
        @(negedge clk_i); rst_n_i = 1'b0; run_i = 1'b0;
        @(negedge clk_i); rst_n_i = 1'b1;

        // Random program run
        gen_program();
        idx = 0; cur = 0; waited = 0; done_loop = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < 20000 && !done_loop; c++) begin
            @(negedge clk_i);
            run_i = (idx < N) ? ($urandom_range(0, 5) != 0) : 1'b0;
            load = 1'b0;
            if (mem_req_o && !mem_addr_sel_o) begin
                if (idx < N && waited >= fw[idx]) begin
                    mem_ready_i = 1'b1; waited = 0; load = 1'b1;
                end else begin
                    mem_ready_i = 1'b0; waited++;
                end
            end else if (mem_req_o) begin
                if (waited >= mw[cur]) begin
                    mem_ready_i = 1'b1; waited = 0;
                end else begin
                    mem_ready_i = 1'b0; waited++;
                end
            end else begin
                mem_ready_i = 1'($urandom_range(0, 1));
                waited = 0;
            end
            @(posedge clk_i); #1;
            if (load) begin
                instr_i = prog[idx]; zero_i = zb[idx]; cur = idx; idx++;
            end
            done_loop = (retired == N) && (state_o == 4'd0);
        end
        @(negedge clk_i); #3;
        mon_en = 1'b0;
        check("all_retired", 32'(retired), 32'(N));
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // Illegal opcode: DECODE then sticky ERR
        @(negedge clk_i); rst_n_i = 1'b0; instr_i = 32'h0000_0013; mem_ready_i = 1'b0;
        @(negedge clk_i); rst_n_i = 1'b1; run_i = 1'b1; mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("illegal_fetch", 32'(state_o), 32'd1);
        @(posedge clk_i); #1;
        check("illegal_decode", 32'(state_o), 32'd2);
        @(posedge clk_i); #1;
        check("err_state", 32'(state_o), 32'd9);
        check("err_flag", 32'(err_o), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i); run_i = ~run_i;
            @(posedge clk_i); #1;
            check("err_sticky_state", 32'(state_o), 32'd9);
            check("err_sticky_strobes", 32'(strobes()), 32'h1);
        end
        @(negedge clk_i); rst_n_i = 1'b0; run_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        check("err_cleared", 32'(err_o), 32'd0);
        check("err_rst_state", 32'(state_o), 32'd0);

        // Memory never ready in FETCH
        @(negedge clk_i); rst_n_i = 1'b1; run_i = 1'b1;
        req_cycles = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk_i); #1;
            if (mem_req_o) req_cycles++;
            if (state_o == 4'd9) break;
        end
`ifdef MEM_TIMEOUT_EN
        check("timeout_req_cycles", 32'(req_cycles), 32'd17);
        check("timeout_state", 32'(state_o), 32'd9);
        check("timeout_err", 32'(err_o), 32'd1);
        check("timeout_req_dropped", 32'(mem_req_o), 32'd0);
`else
        check("no_timeout_req_cycles", 32'(req_cycles), 32'd1000);
        check("no_timeout_state", 32'(state_o), 32'd1);
        check("no_timeout_err", 32'(err_o), 32'd0);
        check("no_timeout_req", 32'(mem_req_o), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences a multi-cycle RV32 datapath over one shared instruction/data memory port.
- Supported opcodes: R-type (0x33), lw (0x03), sw (0x23), beq (0x63).
- Drives IR load, PC update, ALU operand/op select, register-file write, memory request/write select; retires one instruction per pass.
- Sits between the IR/PC/ALU/regfile datapath and the memory port.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive wait cycles on the memory handshake before error (used only with MEM_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- run_i  in  1  start/continue; sampled in IDLE and at each retire
- instr_i  in  32  IR contents (valid from DECODE onward)
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes current request this cycle
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  1 = write (sw data phase)
- mem_addr_sel_o  out  1  0 = PC, 1 = ALU result
- ir_we_o  out  1  load IR
- pc_we_o  out  1  update PC
- pc_src_o  out  1  0 = PC+4, 1 = branch target
- alu_src_o  out  1  0 = rs2, 1 = immediate
- alu_ctrl_o  out  4  0010 add, 0110 sub, 0000 and, 0001 or
- reg_we_o  out  1  regfile write
- mem_to_reg_o  out  1  1 = write-back from memory
- instr_done_o  out  1  one-cycle retire pulse
- err_o  out  1  sticky error
- state_o  out  4  current state code, for debug

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; all outputs 0 except alu_ctrl_o=0010. Mid-transaction reset drops mem_req_o immediately; err_o cleared.
- State codes:
  - IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, ADDR=4, MEM=5, WB_R=6, WB_L=7, BRANCH=8, ERR=9.
- IDLE: run_i=1 -> FETCH.
- FETCH: mem_req_o=1, mem_addr_sel_o=0, mem_we_o=0.
  - mem_ready_i=1: ir_we_o=1 (same cycle, Mealy) -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: opcode=instr_i[6:0].
  - 0x33 -> EXEC_R; 0x03/0x23 -> ADDR; 0x63 -> BRANCH; any other -> ERR.
- EXEC_R: alu_src_o=0; alu_ctrl_o from funct7/funct3.
  - funct7=0x00: funct3 000 -> 0010; 111 -> 0000; all others -> 0001.
  - Any other funct7 -> 0110.
  - Next state WB_R.
- WB_R: alu_ctrl_o held as in EXEC_R; reg_we_o=1, mem_to_reg_o=0, pc_we_o=1, pc_src_o=0; retire.
- ADDR: alu_src_o=1, alu_ctrl_o=0010 -> MEM.
- MEM: mem_req_o=1, mem_addr_sel_o=1, alu_src_o=1, alu_ctrl_o=0010, mem_we_o=(opcode==0x23).
  - On mem_ready_i: lw -> WB_L; sw retires in this cycle (pc_we_o=1, pc_src_o=0).
- WB_L: reg_we_o=1, mem_to_reg_o=1, pc_we_o=1, pc_src_o=0; retire.
- BRANCH: alu_src_o=0, alu_ctrl_o=0110, pc_we_o=1, pc_src_o=zero_i; retire.
- Retire cycle: instr_done_o=1 coincident with pc_we_o. Next state FETCH if run_i=1, else IDLE. Deasserting run_i never aborts an in-flight instruction.
- ERR: all strobes 0, err_o=1; only reset exits ERR. run_i is ignored.
- alu_ctrl_o=0010 in every state not listed above.
- Zero-wait latency (cycles from FETCH entry to retire, inclusive):
  - R-type 4, lw 5, sw 4, beq 3.
  - Each cycle of mem_ready_i=0 adds one.
- mem_req_o never deasserts while waiting. mem_ready_i is ignored outside FETCH/MEM.
- Simultaneous mem_ready_i and reset assertion: reset wins; no ir_we_o.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter clears on entry to FETCH/MEM and on mem_ready_i; increments each cycle of FETCH/MEM with mem_ready_i=0.
  - When the count reaches TIMEOUT_CYCLES: -> ERR, err_o=1, mem_req_o dropped next cycle.
  - TIMEOUT_CYCLES=16 means the 17th consecutive wait cycle is the last cycle with mem_req_o=1.
- Undefined: no counter; FSM waits indefinitely. err_o is set only by an illegal opcode.

Test Plan:
- Reset mid-FETCH with mem_req_o=1 -> all outputs 0 asynchronously, state_o=0. After release, run_i=1 -> FETCH next cycle.
- add (0x00C58533), mem_ready_i always 1 -> states 1,2,3,6; alu_ctrl_o=0010 in EXEC_R; reg_we_o, pc_we_o, instr_done_o high in cycle 4 only.
- lw with 3 wait cycles in MEM -> mem_req_o=1, mem_addr_sel_o=1 for 4 cycles; then WB_L with mem_to_reg_o=1, reg_we_o=1; total 8 cycles.
- beq twice, zero_i=1 then zero_i=0 -> alu_ctrl_o=0110 in both; pc_src_o=1 then 0; 3 cycles each; sw retires without reg_we_o.
- Opcode 0x13 -> DECODE then ERR; err_o=1 and stays 1 with run_i toggling; no pc_we_o or reg_we_o; cleared only by rst_n_i.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready_i held 0 in FETCH -> ERR entered after 17 request cycles; err_o=1. Without macro, still in FETCH after 1000 cycles.
